// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - shared constants and types for the MMIO UART transmitter
// Purpose: register byte offsets, STATUS/CTRL bit positions, TX FSM state type
//          and the baud divisor clamp used by uart_tx_mmio.
// Ports:   none (package).
package uart_mmio_pkg;

   // Byte offsets within the 16-byte register window (only bits [3:2] decode).
   localparam logic [3:0] OFF_TXDATA = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_BAUD   = 4'h8;
   localparam logic [3:0] OFF_CTRL   = 4'hC;

   // STATUS bit positions
   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 8;

   // CTRL bit positions
   localparam int CTRL_TX_EN  = 0;
   localparam int CTRL_IRQ_EN = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // A programmed divisor of zero would never let a bit end; treat it as 1.
   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
// Purpose: byte queue between the register interface and the serializer.
// Ports:   clk, reset (sync, active-high)
//          i_push/i_din  write side; a push while full is accepted only with a pop
//          i_pop/o_dout  read side; o_dout shows the head entry (first-word fall-through)
//          o_full, o_empty, o_count (0..DEPTH, DEPTH encoded distinctly from 0)
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];

   // Full plus simultaneous pop frees the head slot on the same edge.
   assign w_push_ok = i_push & (~o_full | i_pop);
   assign w_pop_ok  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO
// Purpose: decodes core loads/stores in a 16-byte window at BASE_ADDR, queues
//          TXDATA bytes and serializes them LSB first at BAUDDIV clocks per bit.
// Ports:   clk, reset (sync, active-high)
//          mem_read, mem_write, addr, write_data  core data-memory bus
//          read_data  combinational load data, 0 unless a hit load
//          sel        address window hit, used outside to mux against RAM
//          uart_tx    serial line, idles high
//          irq        registered level interrupt: irq_en & fifo empty & idle
module uart_tx_mmio
   import uart_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        sel,
   output logic        uart_tx,
   output logic        irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic            w_hit;
   logic            w_wr;
   logic            w_rd;
   logic [3:0]      w_reg;
   logic            w_push;
   logic            w_pop;
   logic [7:0]      w_fifo_dout;
   logic            w_full;
   logic            w_empty;
   logic [CW-1:0]   w_count;
   logic            w_busy;
   logic            w_bit_end;
   logic            w_can_start;
   logic [15:0]     w_div_m1;
   logic [31:0]     w_status;
   logic            w_unused;

   logic [15:0]     r_baud_div;
   logic [1:0]      r_ctrl;
   logic            r_ovf;
   logic            r_irq;
   tx_state_t       r_state;
   logic [7:0]      r_shift;
   logic [2:0]      r_bit_cnt;
   logic [15:0]     r_baud_cnt;
   logic            r_tx;

   assign w_hit  = (addr[31:4] == BASE_ADDR[31:4]);
   assign sel    = w_hit;
   assign w_wr   = mem_write & w_hit;
   assign w_rd   = mem_read & w_hit;
   assign w_reg  = {addr[3:2], 2'b00};
   assign w_push = w_wr & (w_reg == OFF_TXDATA);
   assign w_unused = &{1'b0, addr[1:0], write_data[31:16]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   (write_data[7:0]),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Bit timer counts down from divisor-1; the divisor is sampled only on
   // reload, so a BAUDDIV change lands on the next bit boundary.
   assign w_div_m1    = eff_div(r_baud_div) - 16'd1;
   assign w_bit_end   = (r_baud_cnt == 16'd0);
   assign w_busy      = (r_state != IDLE);
   assign w_can_start = r_ctrl[CTRL_TX_EN] & ~w_empty;
   assign w_pop       = w_can_start & ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));

   assign w_status = {20'd0, 4'(w_count), 4'd0, r_ovf, w_empty, w_full, w_busy};

   always_comb begin
      read_data = 32'h0;
      if (w_rd) begin
         case (w_reg)
            OFF_STATUS: read_data = w_status;
            OFF_BAUD:   read_data = {16'd0, r_baud_div};
            OFF_CTRL:   read_data = {30'd0, r_ctrl};
            default:    read_data = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_baud_div <= DEFAULT_DIV;
         r_ctrl     <= 2'b01;
         r_ovf      <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         if (w_wr && w_reg == OFF_BAUD) r_baud_div <= write_data[15:0];
         if (w_wr && w_reg == OFF_CTRL) r_ctrl     <= write_data[1:0];
         if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
         end else if (w_wr && w_reg == OFF_STATUS && write_data[ST_OVF]) begin
            r_ovf <= 1'b0;
         end
         r_irq <= r_ctrl[CTRL_IRQ_EN] & w_empty & ~w_busy;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_tx       <= 1'b1;
         r_shift    <= 8'd0;
         r_bit_cnt  <= 3'd0;
         r_baud_cnt <= 16'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift    <= w_fifo_dout;
                  r_tx       <= 1'b0;
                  r_baud_cnt <= w_div_m1;
                  r_state    <= START;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_tx       <= r_shift[0];
                  r_shift    <= r_shift >> 1;
                  r_bit_cnt  <= 3'd0;
                  r_baud_cnt <= w_div_m1;
                  r_state    <= DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt - 16'd1;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_baud_cnt <= w_div_m1;
                  if (r_bit_cnt == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_tx      <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt - 16'd1;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  if (w_pop) begin
                     // Next byte waiting: go straight to its start bit.
                     r_shift    <= w_fifo_dout;
                     r_tx       <= 1'b0;
                     r_baud_cnt <= w_div_m1;
                     r_state    <= START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= IDLE;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt - 16'd1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign uart_tx = r_tx;
   assign irq     = r_irq;

endmodule
